// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial bit-pattern transmitter. On a start pulse it latches a
//            PAT_W-bit pattern and a repetition count, shifts the pattern out
//            MSB-first that many times on a single wire, then pulses done.
//            Optional macro SEQ_GEN_GAP_EN inserts one idle bit between
//            consecutive repetitions so a downstream detector resynchronises.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int              PAT_W   = 3,
    parameter logic [PAT_W-1:0] DEF_PAT = 3'b110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       reps,
    output logic             ser_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int              IDX_W     = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] c_IDX_MSB = IDX_W'(PAT_W - 1);

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    // Control state and latched transaction
    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_reps;

    // Registered outputs
    logic             r_ser_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    // Next-state values
    state_t           w_state_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [3:0]       w_reps_nxt;
    logic             w_ser_nxt;
    logic             w_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // State, datapath and output registers; rst overrides everything, including start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pat     <= DEF_PAT;
            r_idx     <= '0;
            r_reps    <= '0;
            r_ser_out <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pat     <= w_pat_nxt;
            r_idx     <= w_idx_nxt;
            r_reps    <= w_reps_nxt;
            r_ser_out <= w_ser_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and output decode; outputs describe the current state and
    // appear one edge later, giving the one-cycle start-to-first-bit latency
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_idx_nxt   = r_idx;
        w_reps_nxt  = r_reps;
        w_ser_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pat_nxt  = pattern;
                    w_reps_nxt = reps;
                    w_idx_nxt  = c_IDX_MSB;
                    // A zero count still completes, just without any bits
                    w_state_nxt = (reps != 4'd0) ? S_SEND : S_DONE;
                end
            end

            S_SEND: begin
                w_ser_nxt   = r_pat[r_idx];
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
                if (r_idx == '0) begin
                    // Counter is tested before decrementing, so it never wraps
                    w_reps_nxt = r_reps - 4'd1;
                    if (r_reps > 4'd1) begin
`ifdef SEQ_GEN_GAP_EN
                        w_state_nxt = S_GAP;
`else
                        w_idx_nxt   = c_IDX_MSB;
`endif
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end

`ifdef SEQ_GEN_GAP_EN
            S_GAP: begin
                w_busy_nxt  = 1'b1;
                w_idx_nxt   = c_IDX_MSB;
                w_state_nxt = S_SEND;
            end
`endif

            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ser_out = r_ser_out;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern transmitter that drives a one-bit stream into the team's serial sequence detectors, one bit per clock. On a start pulse it latches a PAT_W-bit pattern and a repetition count, then shifts the pattern out MSB-first the requested number of times and pulses done. It is the stimulus and transmit side of the detector's single-wire input, for both on-chip self-test and board demos.

## Interface
- PAT_W, 3: pattern length in bits; legal range 2..16.
- DEF_PAT, 3'b110: value loaded into the pattern register at reset (width PAT_W).

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high. It is sampled only on the rising edge of clk.
- start  in  1  request pulse; accepted only in IDLE.
- pattern  in  PAT_W  pattern to send, MSB first; sampled at the accepting edge.
- reps  in  4  number of repetitions, 0..15; sampled at the accepting edge.
- ser_out  out  1  serial data; 0 when not sending a pattern bit.
- valid  out  1  high while ser_out carries a pattern bit.
- busy  out  1  high from the first bit cycle through the last bit cycle, including gaps.
- done  out  1  one-cycle completion pulse.

## Operation
- All outputs registered. Reset values: ser_out=0, valid=0, busy=0, done=0. Internal registers after reset:
  - state=IDLE
  - pattern register = DEF_PAT
  - bit counter = 0
  - repetition counter = 0
- States:
  - IDLE: waits for start.
  - SEND: emits pattern bits.
  - GAP: emits one idle bit between repetitions; exists only with the gap feature.
  - DONE: asserts done for one cycle.
- IDLE with start=1:
  - Latch pattern and reps.
  - If reps≠0, go to SEND with bit index PAT_W-1 and repetition counter = reps.
  - If reps=0, go to DONE; no bits are emitted.
- SEND: ser_out = pattern[bit index], valid=1, busy=1. The index decrements each cycle. At index 0:
  - Decrement the repetition counter.
  - If repetitions remain, go to GAP (gap feature enabled) or reload index PAT_W-1 and stay in SEND (disabled).
  - Otherwise go to DONE.
- GAP: ser_out=0, valid=0, busy=1 for exactly one cycle, then SEND with index PAT_W-1.
- DONE: done=1, busy=0, valid=0, ser_out=0 for one cycle, then IDLE.
- start is ignored in SEND, GAP and DONE; no queuing. The latched pattern and reps are not affected by input changes after acceptance.
- Counters:
  - Bit index width is ceil(log2(PAT_W)).
  - Repetition counter is 4 bits and never wraps, because it is checked before it is decremented.
- rst asserted in any state, including mid-pattern: the next edge forces the reset values and IDLE. There is no done pulse, and the partially sent pattern is abandoned.

## Timing
- start accepted at edge k. The first bit (pattern MSB) appears on ser_out after edge k+1. Latency is 1 cycle.
- Each bit is held exactly one clock.
- Gap feature disabled:
  - Bits occupy cycles k+1 .. k+reps·PAT_W, back to back.
  - done is high in cycle k+reps·PAT_W+1.
- Gap feature enabled:
  - Bits plus gaps occupy cycles k+1 .. k+reps·PAT_W+(reps−1).
  - done follows in the next cycle.
- reps=0: done is high in cycle k+1.
- Earliest next acceptance is the cycle after done, i.e. start sampled in IDLE.
- start and rst high on the same edge: rst wins.

## Configuration
- SEQ_GEN_GAP_EN:
  - Defined: the GAP state exists. Exactly one ser_out=0, valid=0 cycle is inserted between consecutive repetitions, never after the last one. This guarantees the downstream detector returns to its start state between patterns.
  - Undefined: the GAP state is not compiled and repetitions are sent back to back.

## Test plan
- Reset, then idle: rst=1 for 2 cycles, then rst=0 with no start -> ser_out=0, valid=0, busy=0, done=0 on every cycle.
- PAT_W=3, pattern=3'b110, reps=2, start at edge k, SEQ_GEN_GAP_EN undefined -> ser_out = 1,1,0,1,1,0 in cycles k+1..k+6 with valid=1; done=1 only in k+7; busy falls in k+7.
- Same stimulus with SEQ_GEN_GAP_EN defined -> ser_out = 1,1,0,0,1,1,0 in cycles k+1..k+7; valid=0 only in k+4; done=1 in k+8.
- reps=0, start=1 -> no valid cycles; done=1 in k+1 only; busy stays 0.
- pattern=3'b101, reps=3; change the pattern input to 3'b000 and pulse start again in k+2 -> the second start is ignored and the output is still three repetitions of 1,0,1.
- reps=4, assert rst in the 5th bit cycle -> next cycle all outputs 0, state IDLE, no done pulse. A new start with reps=1 afterwards sends exactly one full pattern.
